ngc_fifo_reader: RTL and testbench

- Read-side master for ngc_fifo: issues pops, captures the FIFO's registered dout one cycle later, and presents the words on a valid/ready output stream.
- Sits between an ngc_fifo instance and any stream consumer.
- Prefetches into a 3-entry output buffer so sustained throughput is 1 word/cycle.
- Has no combinational path from m_ready to fifo_pop.

---
 rtl/ngc_fifo_pkg.sv | 17 +
 rtl/ngc_fifo_reader_buf.sv | 75 +++++++
 rtl/ngc_fifo_reader.sv | 92 +++++++++
 tb/tb_ngc_fifo_reader.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ngc_fifo_pkg.sv
// Shared defaults, word type and pointer sizing for the ngc_fifo read-side logic.
package ngc_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BUF_DEPTH_DEF  = 3;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Pointer width for a buffer of the given depth, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        if (depth > 1) begin
            return 32'($clog2(depth));
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/ngc_fifo_reader_buf.sv
// Circular register buffer for ngc_fifo_reader: push at the write pointer, pop at the
// read pointer, head word always visible on data_o.
module ngc_fifo_reader_buf
    import ngc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [OCC_W-1:0]      occ_o
);

    localparam int unsigned PTR_W = ptr_width(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign data_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

    // Credit accounting upstream guarantees a full buffer is never written.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (occ_q == OCC_W'(BUF_DEPTH))));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        occ_q <= OCC_W'(BUF_DEPTH));

endmodule

// File: rtl/ngc_fifo_reader.sv
// Read-side master for ngc_fifo: credit-limited pop issue, 1-cycle dout capture, valid/ready out.
// Define NGC_FIFO_READER_COUNT_EN to add the beat_count output and count_clr input.
module ngc_fifo_reader
    import ngc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef NGC_FIFO_READER_COUNT_EN
    input  logic                  count_clr,
    output logic [31:0]           beat_count,
`endif
    input  logic                  en,
    output logic                  fifo_pop,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CRD_W = OCC_W + 1;

    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic [CRD_W-1:0] used;
    logic             handshake;

    // Credits count words already buffered plus the one whose dout lands next cycle.
    assign used      = CRD_W'(occ) + CRD_W'(inflight_q);
    assign fifo_pop  = rst_n && en && !fifo_empty && (used < CRD_W'(BUF_DEPTH));
    assign m_valid   = (occ != '0);
    assign handshake = m_valid && m_ready;
    assign busy      = (occ != '0) || inflight_q;

    always_comb begin
        inflight_d = fifo_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    ngc_fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .pop_i       (handshake),
        .data_o      (m_data),
        .occ_o       (occ)
    );

`ifdef NGC_FIFO_READER_COUNT_EN
    logic [31:0] beat_count_q, beat_count_d;

    // Clear wins over a coincident handshake.
    always_comb begin
        beat_count_d = beat_count_q;
        if (count_clr) begin
            beat_count_d = '0;
        end else if (handshake) begin
            beat_count_d = beat_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
`endif

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_pop && fifo_empty));

endmodule

// File: tb/tb_ngc_fifo_reader.sv
// Bench for ngc_fifo_reader: depth-3 and depth-5 instances fed by a queue-based FIFO model.
module tb_ngc_fifo_reader;
    import ngc_fifo_pkg::*;

    localparam int unsigned DW = DATA_WIDTH_DEF;
    localparam int unsigned D0 = 3;
    localparam int unsigned D1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en         [2];
    logic          fifo_pop   [2];
    logic          fifo_empty [2];
    logic [DW-1:0] fifo_dout  [2];
    logic [DW-1:0] m_data     [2];
    logic          m_valid    [2];
    logic          m_ready    [2];
    logic          busy       [2];
`ifdef NGC_FIFO_READER_COUNT_EN
    logic          count_clr  [2];
    logic [31:0]   beat_count [2];
`endif

    int checks;
    int errors;

    data_t fq [2][$];
    data_t sb [2][$];

    ngc_fifo_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(D0)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
`ifdef NGC_FIFO_READER_COUNT_EN
        .count_clr(count_clr[0]), .beat_count(beat_count[0]),
`endif
        .en(en[0]), .fifo_pop(fifo_pop[0]), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .busy(busy[0])
    );

    ngc_fifo_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(D1)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
`ifdef NGC_FIFO_READER_COUNT_EN
        .count_clr(count_clr[1]), .beat_count(beat_count[1]),
`endif
        .en(en[1]), .fifo_pop(fifo_pop[1]), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .busy(busy[1])
    );

    // FIFO model: registered dout, one word per accepted pop.
    always @(posedge clk) begin
        if (fifo_pop[0] && fq[0].size() != 0) fifo_dout[0] <= fq[0].pop_front();
        if (fifo_pop[1] && fq[1].size() != 0) fifo_dout[1] <= fq[1].pop_front();
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh();
        fifo_empty[0] = (fq[0].size() == 0);
        fifo_empty[1] = (fq[1].size() == 0);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0;
            m_ready[k] = 1'b0;
            fq[k].delete();
            sb[k].delete();
`ifdef NGC_FIFO_READER_COUNT_EN
            count_clr[k] = 1'b0;
`endif
        end
        refresh();
        advance();
        advance();
        rst_n = 1'b1;
        refresh();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (fifo_pop[k] !== 1'b0 || m_valid[k] !== 1'b0 || busy[k] !== 1'b0 || m_data[k] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got pop=%b valid=%b busy=%b data=%h want 0 0 0 00",
                         k, fifo_pop[k], m_valid[k], busy[k], m_data[k]);
            end
`ifdef NGC_FIFO_READER_COUNT_EN
            checks++;
            if (beat_count[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_count dut%0d got %0d want 0", k, beat_count[k]);
            end
`endif
        end
        advance();
        rst_n = 1'b1;
        refresh();
    endtask

    task automatic test_basic();
        logic [5:0] pop_pat;
        logic [5:0] val_pat;
        logic [5:0] busy_pat;
        data_t      dat [6];
        pop_pat  = 6'b000111;
        val_pat  = 6'b011100;
        busy_pat = 6'b011110;
        dat      = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        do_reset();
        fq[0].push_back(8'h11);
        fq[0].push_back(8'h22);
        fq[0].push_back(8'h33);
        en[0] = 1'b1;
        m_ready[0] = 1'b1;
        refresh();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                advance();
                refresh();
            end
            checks++;
            if (fifo_pop[0] !== pop_pat[c] || m_valid[0] !== val_pat[c] || busy[0] !== busy_pat[c]) begin
                errors++;
                $display("FAIL basic_ctrl cycle %0d got pop=%b valid=%b busy=%b want %b %b %b",
                         c, fifo_pop[0], m_valid[0], busy[0], pop_pat[c], val_pat[c], busy_pat[c]);
            end
            if (val_pat[c]) begin
                checks++;
                if (m_data[0] !== dat[c]) begin
                    errors++;
                    $display("FAIL basic_data cycle %0d got %h want %h", c, m_data[0], dat[c]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int pops;
        pops = 0;
        do_reset();
        for (int i = 1; i <= 10; i++) fq[0].push_back(DW'(17 * i));
        en[0] = 1'b1;
        m_ready[0] = 1'b0;
        refresh();
        for (int c = 0; c < 8; c++) begin
            if (fifo_pop[0] === 1'b1) pops++;
            if (m_valid[0] === 1'b1) begin
                checks++;
                if (m_data[0] !== 8'h11) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d got %h want 11", c, m_data[0]);
                end
            end
            advance();
            refresh();
        end
        checks++;
        if (pops != 3 || m_valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got pops=%0d valid=%b busy=%b want 3 1 1", pops, m_valid[0], busy[0]);
        end
        m_ready[0] = 1'b1;
        refresh();
        // Full buffer plus refill must stream 10 words on 10 consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid[0] !== 1'b1 || m_data[0] !== DW'(17 * (i + 1))) begin
                errors++;
                $display("FAIL bp_drain beat %0d got valid=%b data=%h want 1 %h",
                         i, m_valid[0], m_data[0], DW'(17 * (i + 1)));
            end
            advance();
            refresh();
        end
        checks++;
        if (m_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle got valid=%b busy=%b want 0 0", m_valid[0], busy[0]);
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        for (int i = 0; i < 5; i++) fq[0].push_back(DW'(8'hA0 + i));
        en[0] = 1'b1;
        m_ready[0] = 1'b0;
        refresh();
        checks++;
        if (fifo_pop[0] !== 1'b1) begin
            errors++;
            $display("FAIL endrop_first_pop got %b want 1", fifo_pop[0]);
        end
        advance();
        en[0] = 1'b0;
        refresh();
        checks++;
        if (fifo_pop[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL endrop_inflight got pop=%b busy=%b want 0 1", fifo_pop[0], busy[0]);
        end
        for (int c = 0; c < 4; c++) begin
            advance();
            refresh();
            checks++;
            if (fifo_pop[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_data[0] !== 8'hA0) begin
                errors++;
                $display("FAIL endrop_hold cycle %0d got pop=%b valid=%b data=%h want 0 1 a0",
                         c, fifo_pop[0], m_valid[0], m_data[0]);
            end
        end
        m_ready[0] = 1'b1;
        refresh();
        advance();
        m_ready[0] = 1'b0;
        refresh();
        checks++;
        if (m_valid[0] !== 1'b0 || busy[0] !== 1'b0 || fifo_pop[0] !== 1'b0) begin
            errors++;
            $display("FAIL endrop_idle got valid=%b busy=%b pop=%b want 0 0 0", m_valid[0], busy[0], fifo_pop[0]);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        int cyc;
        do_reset();
        for (int i = 1; i <= 10; i++) fq[0].push_back(DW'(8'h30 + i));
        en[0] = 1'b1;
        m_ready[0] = 1'b0;
        refresh();
        for (int c = 0; c < 3; c++) begin
            advance();
            refresh();
        end
        // Two words buffered and 0x33 in flight; reset must discard all three.
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid[0] !== 1'b0 || busy[0] !== 1'b0 || fifo_pop[0] !== 1'b0 || m_data[0] !== '0) begin
            errors++;
            $display("FAIL midrst_async got valid=%b busy=%b pop=%b data=%h want 0 0 0 00",
                     m_valid[0], busy[0], fifo_pop[0], m_data[0]);
        end
        advance();
        rst_n = 1'b1;
        m_ready[0] = 1'b1;
        refresh();
        got = 0;
        cyc = 0;
        while (got < 7 && cyc < 30) begin
            if (m_valid[0] === 1'b1) begin
                checks++;
                if (m_data[0] !== DW'(8'h34 + got)) begin
                    errors++;
                    $display("FAIL midrst_order beat %0d got %h want %h", got, m_data[0], DW'(8'h34 + got));
                end
                got++;
            end
            advance();
            refresh();
            cyc++;
        end
        checks++;
        if (got != 7) begin
            errors++;
            $display("FAIL midrst_count got %0d words want 7", got);
        end
    endtask

    task automatic test_random();
        int    pushed [2];
        int    recv   [2];
        int    pops   [2];
        logic  stall  [2];
        data_t held   [2];
        data_t w;
        int    cyc;
        int    dep;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pushed[k] = 0;
            recv[k]   = 0;
            pops[k]   = 0;
            stall[k]  = 1'b0;
            held[k]   = '0;
            en[k]     = 1'b1;
        end
        cyc = 0;
        while ((recv[0] < 1000 || recv[1] < 1000) && cyc < 20000) begin
            for (int k = 0; k < 2; k++) begin
                if (pushed[k] < 1000 && $urandom_range(0, 1) == 1) begin
                    w = data_t'($urandom);
                    fq[k].push_back(w);
                    sb[k].push_back(w);
                    pushed[k]++;
                end
                m_ready[k] = 1'($urandom_range(0, 1));
            end
            refresh();
            for (int k = 0; k < 2; k++) begin
                dep = (k == 0) ? int'(D0) : int'(D1);
                if (stall[k]) begin
                    checks++;
                    if (m_valid[k] !== 1'b1 || m_data[k] !== held[k]) begin
                        errors++;
                        $display("FAIL rnd_stable dut%0d cycle %0d got valid=%b data=%h want 1 %h",
                                 k, cyc, m_valid[k], m_data[k], held[k]);
                    end
                end
                if (fifo_pop[k] === 1'b1) begin
                    checks++;
                    if (fq[k].size() == 0) begin
                        errors++;
                        $display("FAIL rnd_pop_empty dut%0d cycle %0d got pop=1 want 0", k, cyc);
                    end
                    pops[k]++;
                    checks++;
                    if (pops[k] - recv[k] > dep) begin
                        errors++;
                        $display("FAIL rnd_credit dut%0d cycle %0d got outstanding=%0d want <=%0d",
                                 k, cyc, pops[k] - recv[k], dep);
                    end
                end
                if (m_valid[k] === 1'b1 && m_ready[k] === 1'b1) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL rnd_phantom dut%0d cycle %0d got %h want nothing", k, cyc, m_data[k]);
                    end else begin
                        w = sb[k].pop_front();
                        if (m_data[k] !== w) begin
                            errors++;
                            $display("FAIL rnd_data dut%0d word %0d got %h want %h", k, recv[k], m_data[k], w);
                        end
                    end
                    recv[k]++;
                end
                stall[k] = (m_valid[k] === 1'b1) && (m_ready[k] !== 1'b1);
                held[k]  = m_data[k];
            end
            advance();
            cyc++;
        end
        refresh();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (recv[k] != 1000 || m_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL rnd_done dut%0d got recv=%0d valid=%b busy=%b want 1000 0 0",
                         k, recv[k], m_valid[k], busy[k]);
            end
            en[k] = 1'b0;
            m_ready[k] = 1'b0;
        end
    endtask

`ifdef NGC_FIFO_READER_COUNT_EN
    task automatic test_count();
        int hs;
        int cyc;
        do_reset();
        for (int i = 0; i < 5; i++) fq[0].push_back(DW'(i + 1));
        en[0] = 1'b1;
        m_ready[0] = 1'b1;
        refresh();
        hs = 0;
        cyc = 0;
        while (hs < 5 && cyc < 50) begin
            if (m_valid[0] === 1'b1) hs++;
            advance();
            refresh();
            cyc++;
        end
        checks++;
        if (beat_count[0] !== 32'd5) begin
            errors++;
            $display("FAIL count_five got %0d want 5", beat_count[0]);
        end
        m_ready[0] = 1'b0;
        fq[0].push_back(8'h77);
        refresh();
        cyc = 0;
        while (m_valid[0] !== 1'b1 && cyc < 20) begin
            advance();
            refresh();
            cyc++;
        end
        count_clr[0] = 1'b1;
        m_ready[0] = 1'b1;
        refresh();
        advance();
        count_clr[0] = 1'b0;
        m_ready[0] = 1'b0;
        refresh();
        checks++;
        if (beat_count[0] !== 32'd0 || m_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL count_clr got count=%0d valid=%b want 0 0", beat_count[0], m_valid[0]);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        fifo_dout[0] = '0;
        fifo_dout[1] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_en_drop();
        test_reset_mid();
        test_random();
`ifdef NGC_FIFO_READER_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
